// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Holds the access bundle, port ids and RISC-V func3 codes.
package dmem_arb_pkg;

  localparam int DMEM_AW = 9;
  localparam int DMEM_DW = 32;

  typedef enum logic {
    PORT_PIPE = 1'b0,
    PORT_AUX  = 1'b1
  } port_e;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
    logic [2:0]         func3;
  } mem_req_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic int burst_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and datamemory.
// slave: arbiter side; master: requesters plus memory side.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [DM_ADDRESS-1:0] addr0;
  logic [DM_ADDRESS-1:0] addr1;
  logic [DATA_W-1:0]     wdata0;
  logic [DATA_W-1:0]     wdata1;
  logic [2:0]            func3_0;
  logic [2:0]            func3_1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  rvalid0;
  logic                  rvalid1;
  logic [DATA_W-1:0]     rdata0;
  logic [DATA_W-1:0]     rdata1;
  logic                  stall0;
  logic                  mem_read;
  logic                  mem_write;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_func3;
  logic [DATA_W-1:0]     mem_rd;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  func3_0, func3_1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata0, rdata1, stall0,
    output mem_read, mem_write, mem_a,
    output mem_wd, mem_func3
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output func3_0, func3_1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata0, rdata1, stall0,
    input  mem_read, mem_write, mem_a,
    input  mem_wd, mem_func3
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection for the two memory ports.
// DMEM_ARB_RR_EN: round-robin via last_port, else burst-limited priority.
import dmem_arb_pkg::*;

module dmem_arb_pick #(
  parameter int MAX_BURST = 4,
  parameter int BW        = 3
) (
  input  logic          req0,
  input  logic          req1,
`ifdef DMEM_ARB_RR_EN
  input  port_e         last_port,
`else
  input  logic [BW-1:0] burst_cnt,
`endif
  output logic          gnt0,
  output logic          gnt1,
  output port_e         winner
);

  port_e tie;

`ifdef DMEM_ARB_RR_EN
  // Whoever went last yields the next tie.
  assign tie = (last_port == PORT_AUX)
             ? PORT_PIPE : PORT_AUX;
`else
  // Port 1 only wins a tie once port 0 used its burst.
  assign tie = (burst_cnt == BW'(MAX_BURST))
             ? PORT_AUX : PORT_PIPE;
`endif

  always_comb begin
    winner = PORT_PIPE;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    unique case (1'b1)
      (req0 && req1): winner = tie;
      (req0 && !req1): winner = PORT_PIPE;
      (!req0 && req1): winner = PORT_AUX;
      default: winner = PORT_PIPE;
    endcase
    gnt0 = (req0 || req1) && (winner == PORT_PIPE);
    gnt1 = (req0 || req1) && (winner == PORT_AUX);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one datamemory between the MEM stage (port 0) and an aux port.
// ARB -> ACC -> RSP pipeline; bus: dmem_arbiter_if.slave; DMEM_ARB_RR_EN.
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int BW = burst_w(MAX_BURST);

  port_e                 winner;
  logic                  any_req;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_func3;

  logic                  acc_valid;
  port_e                 acc_port;
  mem_req_t              acc_req;

  logic                  rsp_valid;
  port_e                 rsp_port;
  logic [DATA_W-1:0]     rsp_data;

  assign any_req = bus.req0 || bus.req1;

`ifdef DMEM_ARB_RR_EN
  port_e last_port;

  dmem_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_port (last_port),
    .gnt0      (bus.gnt0),
    .gnt1      (bus.gnt1),
    .winner    (winner)
  );

  // Reset to AUX so the very first tie goes to the pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_port <= PORT_AUX;
    end else if (any_req) begin
      last_port <= winner;
    end
  end
`else
  logic [BW-1:0] burst_cnt;

  dmem_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_pick (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .burst_cnt (burst_cnt),
    .gnt0      (bus.gnt0),
    .gnt1      (bus.gnt1),
    .winner    (winner)
  );

  // Counts port-0 wins only while port 1 is kept waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (!bus.req1 || bus.gnt1) begin
      burst_cnt <= '0;
    end else if (bus.gnt0 &&
                 burst_cnt != BW'(MAX_BURST)) begin
      burst_cnt <= burst_cnt + BW'(1);
    end
  end
`endif

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    sel_func3 = bus.func3_0;
    if (winner == PORT_AUX) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
      sel_func3 = bus.func3_1;
    end
  end

  // ACC: acc_req is left alone when idle so mem_a/wd/func3 hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_port  <= PORT_PIPE;
      acc_req   <= '0;
    end else begin
      acc_valid <= any_req;
      if (any_req) begin
        acc_port <= winner;
        acc_req  <= '{we:    sel_we,
                      addr:  sel_addr,
                      wdata: sel_wdata,
                      func3: sel_func3};
      end
    end
  end

  assign bus.mem_read  = acc_valid && !acc_req.we;
  assign bus.mem_write = acc_valid && acc_req.we;
  assign bus.mem_a     = acc_req.addr;
  assign bus.mem_wd    = acc_req.wdata;
  assign bus.mem_func3 = acc_req.func3;

  // RSP: stores complete with zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_port  <= PORT_PIPE;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= acc_valid;
      if (acc_valid) begin
        rsp_port <= acc_port;
        rsp_data <= acc_req.we ? '0 : bus.mem_rd;
      end
    end
  end

  assign bus.rvalid0 = rsp_valid && (rsp_port == PORT_PIPE);
  assign bus.rvalid1 = rsp_valid && (rsp_port == PORT_AUX);
  assign bus.rdata0  = bus.rvalid0 ? rsp_data : '0;
  assign bus.rdata1  = bus.rvalid1 ? rsp_data : '0;
  assign bus.stall0  = bus.req0 && !bus.gnt0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural datamemory.
// Scoreboard queue of expected responses, popped on each rvalid.
import dmem_arb_pkg::*;

module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

  dmem_arbiter #(
    .DM_ADDRESS (9),
    .DATA_W     (32),
    .MAX_BURST  (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          rsp_cyc[$];
  int          rsp_prt[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] mem [0:511];
  logic [31:0] sh  [0:511];
  exp_t        mon_e;

  function automatic logic [31:0] ld_fn(
    input logic [31:0] w, input logic [2:0] f);
    case (f)
      F3_B:  return {{24{w[7]}}, w[7:0]};
      F3_H:  return {{16{w[15]}}, w[15:0]};
      F3_BU: return {24'h0, w[7:0]};
      F3_HU: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_fn(
    input logic [31:0] o, input logic [31:0] d,
    input logic [2:0] f);
    case (f)
      F3_B:    return {o[31:8], d[7:0]};
      F3_H:    return {o[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // datamemory stand-in: combinational read, write at the edge
  assign bus.mem_rd = ld_fn(mem[bus.mem_a], bus.mem_func3);
  always @(posedge clk)
    if (bus.mem_write)
      mem[bus.mem_a] <= st_fn(mem[bus.mem_a], bus.mem_wd,
                              bus.mem_func3);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && (bus.rvalid0 || bus.rvalid1)) begin
      rsp_cyc.push_back(cyc);
      rsp_prt.push_back(bus.rvalid1 ? 1 : 0);
      n_checks++;
      if (bus.rvalid0 && bus.rvalid1) begin
        n_fail++;
        $display("FAIL rvalid_both: both rvalid high");
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_extra: rvalid%0d with empty scoreboard",
                 bus.rvalid1);
      end else begin
        mon_e = sb.pop_front();
        if (bus.rvalid1 !== mon_e.port ||
            (mon_e.port ? bus.rdata1 : bus.rdata0)
              !== mon_e.data) begin
          n_fail++;
          $display("FAIL rsp_data: got port %0d data %h, need port %0d data %h",
                   bus.rvalid1,
                   bus.rvalid1 ? bus.rdata1 : bus.rdata0,
                   mon_e.port, mon_e.data);
        end
      end
    end
  end

  task automatic push(input bit p, input logic we,
                      input logic [8:0] a,
                      input logic [31:0] d,
                      input logic [2:0] f);
    exp_t e;
    e.port = p;
    if (we) begin
      sh[a]  = st_fn(sh[a], d, f);
      e.data = 32'h0;
    end else begin
      e.data = ld_fn(sh[a], f);
    end
    sb.push_back(e);
  endtask

  // one ARB cycle: sample grants mid-cycle, log accepted requests
  task automatic step(output bit g0, output bit g1,
                      output bit s0);
    @(negedge clk);
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    s0 = bus.stall0;
    if (bus.req0 && g0)
      push(1'b0, bus.we0, bus.addr0, bus.wdata0, bus.func3_0);
    if (bus.req1 && g1)
      push(1'b1, bus.we1, bus.addr1, bus.wdata1, bus.func3_1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses missing, need 0",
               tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1, bus.mem_read,
         bus.mem_write, bus.gnt0, bus.gnt1} !== 6'b0 ||
        bus.rdata0 !== 32'h0 || bus.rdata1 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: rv %b%b rd %h %h mr %b mw %b, need zeros",
               bus.rvalid0, bus.rvalid1, bus.rdata0, bus.rdata1,
               bus.mem_read, bus.mem_write);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    bit g0, g1, s0;
    bus.req0    = 1'b1;
    bus.we0     = 1'b1;
    bus.addr0   = 9'h010;
    bus.wdata0  = 32'hDEADBEEF;
    bus.func3_0 = F3_W;
    @(negedge clk);
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_gnt: gnt0 %b, need 1", bus.gnt0);
    end
    @(posedge clk);
    #1;
    idle();
    n_checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_a !== 9'h010) begin
      n_fail++;
      $display("FAIL rst_mid_acc: mem_write %b a %h, need 1 010",
               bus.mem_write, bus.mem_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: mem_write %b, need 0",
               bus.mem_write);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_rvalid: rvalid0 %b, need 0",
               bus.rvalid0);
    end
    rst_n = 1'b1;
    bus.we0     = 1'b0;
    bus.req0    = 1'b1;
    step(g0, g1, s0);
    idle();
    drain("rst_mid");
  endtask

  task automatic test_single_load();
    bit g0, g1, s0;
    bus.req0    = 1'b1;
    bus.we0     = 1'b0;
    bus.addr0   = 9'h005;
    bus.func3_0 = F3_W;
    n_checks++;
    if (bus.mem_read !== 1'b0) begin
      n_fail++;
      $display("FAIL load_idle: mem_read %b, need 0", bus.mem_read);
    end
    step(g0, g1, s0);
    idle();
    n_checks++;
    if (g0 !== 1'b1 || g1 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_gnt: gnt %b%b, need 01", g1, g0);
    end
    n_checks++;
    if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 ||
        bus.mem_a !== 9'h005 || bus.mem_func3 !== F3_W ||
        bus.rvalid0 !== 1'b0) begin
      n_fail++;
      $display("FAIL load_acc: mr %b mw %b a %h f3 %b rv %b, need 1 0 005 010 0",
               bus.mem_read, bus.mem_write, bus.mem_a,
               bus.mem_func3, bus.rvalid0);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL load_rsp: rvalid0 %b rdata0 %h, need 1 12345678",
               bus.rvalid0, bus.rdata0);
    end
    drain("load");
  endtask

  task automatic test_store_load();
    bit g0, g1, s0;
    rsp_prt.delete();
    bus.req1    = 1'b1;
    bus.we1     = 1'b1;
    bus.addr1   = 9'h1FF;
    bus.wdata1  = 32'h000000AB;
    bus.func3_1 = F3_B;
    step(g0, g1, s0);
    n_checks++;
    if (g1 !== 1'b1 || g0 !== 1'b0) begin
      n_fail++;
      $display("FAIL st_gnt: gnt %b%b, need 10", g1, g0);
    end
    bus.we1     = 1'b0;
    bus.func3_1 = F3_BU;
    step(g0, g1, s0);
    idle();
    n_checks++;
    if (g1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_gnt: gnt1 %b, need 1", g1);
    end
    drain("st_ld");
    n_checks++;
    if (rsp_prt.size() != 2 || rsp_prt[0] != 1 ||
        rsp_prt[1] != 1) begin
      n_fail++;
      $display("FAIL st_ld_count: %0d port-1 responses, need 2",
               rsp_prt.size());
    end
  endtask

  task automatic test_burst();
    bit g0, g1, s0;
    int exp_seq[10];
`ifdef DMEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req0    = 1'b1;
    bus.req1    = 1'b1;
    bus.we0     = 1'b0;
    bus.we1     = 1'b0;
    bus.func3_0 = F3_W;
    bus.func3_1 = F3_W;
    for (int i = 0; i < 10; i++) begin
      bus.addr0 = 9'(32 + i);
      bus.addr1 = 9'(64 + i);
      step(g0, g1, s0);
      n_checks++;
      if (int'(g1) != exp_seq[i] || g0 == g1 ||
          int'(s0) != exp_seq[i]) begin
        n_fail++;
        $display("FAIL burst_%0d: gnt %b%b stall0 %b, need winner %0d",
                 i, g1, g0, s0, exp_seq[i]);
      end
    end
    idle();
    drain("burst");
  endtask

  task automatic test_back_to_back();
    bit g0, g1, s0;
    int gc;
    rsp_cyc.delete();
    bus.req0    = 1'b1;
    bus.we0     = 1'b0;
    bus.func3_0 = F3_W;
    gc = cyc;
    for (int i = 1; i <= 3; i++) begin
      bus.addr0 = 9'(i);
      step(g0, g1, s0);
      n_checks++;
      if (g0 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_gnt_%0d: gnt0 %b, need 1", i, g0);
      end
    end
    idle();
    drain("b2b");
    @(posedge clk);
    #1;
    n_checks++;
    if (rsp_cyc.size() != 3 || rsp_cyc[0] != gc + 2 ||
        rsp_cyc[1] != gc + 3 || rsp_cyc[2] != gc + 4) begin
      n_fail++;
      $display("FAIL b2b_timing: %0d pulses first at +%0d, need 3 at +2,+3,+4",
               rsp_cyc.size(),
               rsp_cyc.size() > 0 ? rsp_cyc[0] - gc : -1);
    end
    n_checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
        bus.mem_a !== 9'h003) begin
      n_fail++;
      $display("FAIL idle_hold: mr %b mw %b a %h, need 0 0 003",
               bus.mem_read, bus.mem_write, bus.mem_a);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i] = 32'hA5A50000 ^ (i * 32'h01010101);
    end
    mem[9'h005] = 32'h12345678;
    mem[9'h010] = 32'h11111111;
    mem[9'h001] = 32'hCAFE0001;
    mem[9'h002] = 32'hBEEF0002;
    mem[9'h003] = 32'hF00D0003;
    for (int i = 0; i < 512; i++) sh[i] = mem[i];
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    bus.func3_0 = F3_W; bus.func3_1 = F3_W;

    test_reset();
    test_reset_mid_access();
    test_single_load();
    test_store_load();
    test_burst();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port data memory (datamemory). It shares that memory between the pipeline MEM stage (port 0) and a secondary master such as a debug/DMA port (port 1).
- Selects one request per cycle and drives MemRead/MemWrite/a/wd/func3 from a registered access stage.
- Captures the memory's combinational read data and returns it to the winning requester with a registered valid pulse.
- Fixed priority to port 0, with a burst limit that prevents port 1 starvation.

Parameters:
- DM_ADDRESS, 9, word address width; must match datamemory.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive port-0 grants while port 1 is waiting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req0, req1  in  1  request valid, port 0 / port 1
- we0, we1  in  1  1 = store, 0 = load
- addr0, addr1  in  DM_ADDRESS  word address
- wdata0, wdata1  in  DATA_W  store data
- func3_0, func3_1  in  3  RISC-V load/store func3, passed through unchanged
- gnt0, gnt1  out  1  combinational accept; a request transfers when reqN && gntN
- rvalid0, rvalid1  out  1  one-cycle completion pulse, for loads and stores
- rdata0, rdata1  out  DATA_W  load data, valid while rvalidN=1; 0 for stores
- mem_read  out  1  to datamemory MemRead
- mem_write  out  1  to datamemory MemWrite
- mem_a  out  DM_ADDRESS  to datamemory a
- mem_wd  out  DATA_W  to datamemory wd
- mem_func3  out  3  to datamemory func3
- mem_rd  in  DATA_W  from datamemory rd
- stall0  out  1  req0 && !gnt0; the pipeline holds its MEM stage

Behaviour:
- Reset (rst_n=0, asynchronous): registers cleared as below. Any in-flight access is dropped; no rvalid is generated for it and no memory write is issued after reset asserts.
  - acc_valid=0, rsp_valid=0, burst_cnt=0
  - mem_read=0, mem_write=0
  - rvalid0=rvalid1=0, rdata0=rdata1=0
- Pipeline stages (one accept per cycle, back-to-back supported):
  - ARB (cycle N): pick a winner and assert its gnt combinationally. On the clock edge, latch {port, we, addr, wdata, func3} into the ACC register and set acc_valid=1.
  - ACC (cycle N+1): mem_a/mem_wd/mem_func3 come from the ACC register. mem_read=acc_valid&&!we and mem_write=acc_valid&&we. Loads sample mem_rd at the edge into the RSP register; stores commit in datamemory at the same edge.
  - RSP (cycle N+2): rvalid of the owning port=1 and rdata=captured value (0 for stores). Load-to-data latency is 2 cycles after the gnt cycle.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: port 0 wins unless burst_cnt==MAX_BURST, in which case port 1 wins.
  - burst_cnt increments on each port-0 grant while req1=1, saturating at MAX_BURST. It clears on any port-1 grant, or in any cycle where req1=0.
- Ordering: responses return in grant order. A load following a store to the same address one cycle later returns the new data, because the store commits before the load's ACC cycle.
- The arbiter never stalls internally. A gnt is always issued if any req is high.
- Outputs while idle: mem_read=mem_write=0. mem_a, mem_wd and mem_func3 hold their last values.

Optional Feature:
- DMEM_ARB_RR_EN defined: round-robin arbitration. A last_port register (reset 1, so port 0 wins the first tie) alternates priority on ties; burst_cnt and MAX_BURST are unused.
- DMEM_ARB_RR_EN undefined: fixed priority with the burst limit, as above.

Decomposition:
- Package dmem_arb_pkg holds:
  - mem_req_t struct {we, addr, wdata, func3}
  - port_e enum {PORT_PIPE=0, PORT_AUX=1}
  - func3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
- Sub-module dmem_arb_pick: combinational winner selection from req0, req1, burst_cnt and last_port. Outputs gnt0, gnt1 and the winner index.

Test Plan:
- Reset mid-access: req0 store of 0xDEADBEEF to addr 0x010, with rst_n pulled low in its ACC cycle -> mem_write drops immediately, no rvalid0, and a later load of 0x010 returns the old value.
- Single load: req0 load addr 0x005 (mem holds 0x12345678), func3=010 -> gnt0 in cycle N, mem_read=1 in N+1, rvalid0=1 with rdata0=0x12345678 in N+2.
- Store then load: port 1 stores 0x000000AB to addr 0x1FF (func3=000), then loads addr 0x1FF with func3=100 on the next cycle -> rvalid1 twice, second rdata1=0x000000AB.
- Burst limit: req0 and req1 held high for 10 cycles, MAX_BURST=4 -> grant sequence 0,0,0,0,1,0,0,0,0,1; stall0=1 exactly in the port-1 grant cycles.
- Back-to-back ordering: port 0 issues loads to 0x001, 0x002, 0x003 on consecutive cycles -> three consecutive rvalid0 pulses with data in issue order.
- DMEM_ARB_RR_EN build: both ports requesting continuously -> grants alternate 0,1,0,1, and the first tie goes to port 0.
